spi_master_port: RTL

- Byte-wide SPI master (mode 0, MSB first) that consumes the processor's IO write strobe and data byte and drives the spi_clk/mosi/miso/spi_addr pins.
- Sits directly downstream of the processor core's IO decode: the core presents a device address and byte, and the block shifts the byte out while shifting one in.
- Reports busy/done and holds the last received byte for readback.

---
 rtl/spi_master_port.sv | 129 ++++++++++++
 1 files changed

// File: rtl/spi_master_port.sv
// rtl/spi_master_port.sv - byte-wide mode-0 SPI master fed by the core's IO write strobe
// Optional: define SPI_LOOPBACK_EN to add loopback_i (rx samples mosi instead of miso).
module spi_master_port #(
    parameter int CLK_DIV   = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 wr_i,
    input  logic [2:0]           dev_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 spi_clk,
    output logic                 mosi,
    input  logic                 miso,
`ifdef SPI_LOOPBACK_EN
    input  logic                 loopback_i,
`endif
    output logic [2:0]           spi_addr
);

    localparam int            MSB       = DATA_BITS - 1;
    localparam int            EDGE_W    = $clog2(2 * DATA_BITS);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_BITS - 1);
    localparam logic [7:0]    DIV_LAST  = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        DONE
    } state_t;

    state_t               state;
    logic [7:0]           divider;
    logic [EDGE_W-1:0]    edge_cnt;
    logic [DATA_BITS-1:0] tx_shift;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 tick;
    logic                 rx_bit;

    assign tick = (divider == DIV_LAST);

`ifdef SPI_LOOPBACK_EN
    assign rx_bit = loopback_i ? mosi : miso;
`else
    assign rx_bit = miso;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= IDLE;
            divider   <= 8'd0;
            edge_cnt  <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            rx_data_o <= '0;
            spi_clk   <= 1'b0;
            mosi      <= 1'b0;
            spi_addr  <= 3'b000;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    divider <= 8'd0;
                    if (wr_i && dev_i != 3'b000) begin
                        tx_shift <= data_i;
                        spi_addr <= dev_i;
                        mosi     <= data_i[MSB];
                        busy_o   <= 1'b1;
                        edge_cnt <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    divider <= tick ? 8'd0 : divider + 8'd1;
                    if (tick) begin
                        spi_clk  <= 1'b1;
                        rx_shift <= {rx_shift[MSB-1:0], rx_bit};
                        state    <= XFER;
                    end
                end
                XFER: begin
                    divider <= tick ? 8'd0 : divider + 8'd1;
                    if (tick) begin
                        edge_cnt <= edge_cnt + 1'b1;
                        // Last half-period keeps spi_clk low after the 8th falling edge.
                        if (edge_cnt == EDGE_LAST) begin
                            state <= HOLD;
                        end else if (spi_clk) begin
                            spi_clk  <= 1'b0;
                            tx_shift <= tx_shift << 1;
                            mosi     <= tx_shift[MSB-1];
                        end else begin
                            spi_clk  <= 1'b1;
                            rx_shift <= {rx_shift[MSB-1:0], rx_bit};
                        end
                    end
                end
                HOLD: begin
                    divider <= tick ? 8'd0 : divider + 8'd1;
                    // Outputs are registered, so the DONE-cycle values are loaded here.
                    if (tick) begin
                        state     <= DONE;
                        done_o    <= 1'b1;
                        busy_o    <= 1'b0;
                        spi_addr  <= 3'b000;
                        mosi      <= 1'b0;
                        rx_data_o <= rx_shift;
                    end
                end
                DONE: begin
                    divider <= 8'd0;
                    state   <= IDLE;
                end
                default: begin
                    divider <= 8'd0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
